// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// holds the returned instruction until the decoder consumes it.
//
// state | meaning
// REQ   | request at pc presented, waiting for imem_req_ready
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction presented to the decoder
// DRAIN | redirected with a request in flight, discard its response
// HALT  | decoder panic, frozen until reset
module fetch_unit #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  stall,
  input  logic                  panic,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [3:0]            opcode,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  req_fire;

  assign redirect_pc = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
  assign req_fire    = (state_q == S_REQ) && imem_req_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          // an accepted request still owes us a response that must be dropped
          state_d = req_fire ? S_DRAIN : S_REQ;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_resp_valid ? S_REQ : S_DRAIN;
        end else if (imem_resp_valid) begin
          instr_d    = imem_resp_data;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (panic) begin
          state_d = S_HALT;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!stall) begin
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_resp_valid) state_d = S_REQ;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ) && !reset;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == S_HOLD);
  assign halted         = (state_q == S_HALT);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign opcode         = instr_q[DATA_WIDTH-1 -: 4];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: linear cycle-by-cycle steps against a small
// instruction memory responder with selectable latency.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        panic;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [3:0]  opcode;
  logic        halted;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .panic           (panic),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .opcode          (opcode),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  // memory contents: opcode = addr[5:2]^5, low bits echo the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[5:2] ^ 4'h5, a[27:0]};
  endfunction

  int          lat = 1;
  logic        hs_s = 1'b0;
  logic [31:0] addr_s = '0;
  logic        d1_v = 1'b0, d2_v = 1'b0;
  logic [31:0] d1_a = '0, d2_a = '0;

  always @(negedge clk) begin
    #1;
    hs_s   = imem_req_valid && imem_req_ready;
    addr_s = imem_req_addr;
  end

  always @(posedge clk) begin
    #1;
    d2_v = d1_v;
    d2_a = d1_a;
    d1_v = hs_s;
    d1_a = addr_s;
    if (lat == 1) begin
      imem_resp_valid = d1_v;
      imem_resp_data  = d1_v ? mem_word(d1_a) : 32'hDEAD_BEEF;
    end else begin
      imem_resp_valid = d2_v;
      imem_resp_data  = d2_v ? mem_word(d2_a) : 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    stall           = 1'b0;
    panic           = 1'b0;

    // t=10: reset state
    step();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    reset = 1'b0;
    #1;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h0);

    // back-to-back fetches with one-cycle memory
    step();  // t=20 WAIT
    chk("wait0_req_valid", imem_req_valid, 0);
    chk("wait0_instr_valid", instr_valid, 0);
    step();  // t=30 HOLD
    chk("i0_valid", instr_valid, 1);
    chk("i0_pc", instr_pc, 32'h0);
    chk("i0_instr", instr, 32'h5000_0000);
    chk("i0_opcode", opcode, 4'h5);
    step();  // t=40 REQ
    chk("req1_valid", imem_req_valid, 1);
    chk("req1_addr", imem_req_addr, 32'h4);
    chk("req1_instr_valid", instr_valid, 0);
    step(); step();  // t=60
    chk("i1_pc", instr_pc, 32'h4);
    chk("i1_instr", instr, 32'h4000_0004);
    chk("i1_opcode", opcode, 4'h4);
    step();  // t=70
    chk("req2_addr", imem_req_addr, 32'h8);
    step(); step();  // t=90
    chk("i2_valid", instr_valid, 1);
    chk("i2_pc", instr_pc, 32'h8);

    // stall in HOLD for five cycles
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc", instr_pc, 32'h8);
      chk("stall_instr", instr, 32'h7000_0008);
      chk("stall_opcode", opcode, 4'h7);
      chk("stall_no_req", imem_req_valid, 0);
    end
    stall = 1'b0;
    step();  // t=150 REQ at 0xC

    // memory not ready for four cycles
    imem_req_ready = 1'b0;
    chk("nready_valid0", imem_req_valid, 1);
    chk("nready_addr0", imem_req_addr, 32'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nready_valid", imem_req_valid, 1);
      chk("nready_addr", imem_req_addr, 32'hC);
      chk("nready_instr_valid", instr_valid, 0);
    end
    imem_req_ready = 1'b1;  // t=180
    step();  // t=190 WAIT
    chk("ready_wait", imem_req_valid, 0);
    step();  // t=200 HOLD
    chk("i3_pc", instr_pc, 32'hC);
    chk("i3_instr", instr, 32'h6000_000C);

    // redirect in WAIT before the response (two-cycle memory)
    lat = 2;
    step();  // t=210 REQ 0x10
    chk("req4_addr", imem_req_addr, 32'h10);
    step();  // t=220 WAIT, response not yet back
    chk("redir_wait", imem_req_valid, 0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h103;
    step();  // t=230 DRAIN
    redirect_valid = 1'b0;
    chk("drain_no_req", imem_req_valid, 0);
    chk("drain_no_valid", instr_valid, 0);
    step();  // t=240 REQ at redirect target
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_req_addr", imem_req_addr, 32'h100);
    lat = 1;
    step();  // t=250 WAIT
    chk("redir_dropped", instr_valid, 0);
    step();  // t=260 HOLD
    chk("redir_i_valid", instr_valid, 1);
    chk("redir_i_pc", instr_pc, 32'h100);
    chk("redir_i_instr", instr, 32'h5000_0100);

    // panic beats redirect and stall
    panic           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    stall           = 1'b1;
    step();  // t=270 HALT
    panic          = 1'b0;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    chk("halt_halted", halted, 1);
    chk("halt_instr_valid", instr_valid, 0);
    chk("halt_req_valid", imem_req_valid, 0);
    step(); step();  // t=290
    chk("halt_sticky", halted, 1);
    chk("halt_no_req", imem_req_valid, 0);
    reset = 1'b1;
    step();  // t=300 after reset edge
    chk("rst2_halted", halted, 0);
    chk("rst2_req_valid", imem_req_valid, 0);
    chk("rst2_instr", instr, 0);
    reset = 1'b0;
    #1;
    chk("rst2_req_addr", imem_req_addr, 32'h0);
    chk("rst2_req_valid_after", imem_req_valid, 1);

    // redirect coinciding with an accepted request, then PC wraparound
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    step();  // t=310 DRAIN
    redirect_valid = 1'b0;
    chk("hs_redir_drain", imem_req_valid, 0);
    step();  // t=320 REQ
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    step(); step();  // t=340 HOLD
    chk("wrap_i_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_i_instr", instr, 32'hAFFF_FFFC);
    chk("wrap_i_opcode", opcode, 4'hA);
    step();  // t=350
    chk("wrap_next_valid", imem_req_valid, 1);
    chk("wrap_next_addr", imem_req_addr, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
